// File: rtl/fetch_pkg.sv
// Shared types and constants for the Thumb/ARM instruction prefetch stage.
// Address helpers keep PC and fetch-address alignment rules in one place.
package fetch_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] fetch_addr_t;

    localparam fetch_addr_t STEP_THUMB = 32'd2;
    localparam fetch_addr_t STEP_ARM   = 32'd4;

    // Thumb instructions are halfword aligned, ARM instructions word aligned.
    function automatic fetch_addr_t align_pc(input fetch_addr_t addr, input logic thumb);
        return thumb ? {addr[WORD_W-1:1], 1'b0} : {addr[WORD_W-1:2], 2'b00};
    endfunction

    function automatic fetch_addr_t word_align(input fetch_addr_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Small word FIFO with a registered head word; clear overrides push and pop.
// The head register is refreshed every cycle so rdata never depends on pop combinationally.
module fetch_word_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [WORD_W-1:0] head_d;

    // When the slot about to become head is written this cycle, bypass wdata.
    always_comb begin
        rd_next = rd_ptr + PTR_W'(pop);
        head_d  = mem[rd_next];
        if (push && (wr_ptr == rd_next)) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + CNT_W'(push) - CNT_W'(pop);
            rdata  <= head_d;
        end
    end

endmodule

// File: rtl/thumb_fetch_buffer.sv
// Instruction prefetch stage: fetches words into a FIFO and presents them to the
// decoder with a PC that steps by 2 (Thumb) or 4 (ARM); flush redirects the stream.
module thumb_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        thumb,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] code,
    output logic        addr1,
    output logic [31:0] pc
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count;
    logic [31:0]      fifo_rdata;
    logic             ack_ok;
    logic             push;
    logic             pop;
    logic             xfer;

    fetch_addr_t pc_q, pc_d;
    fetch_addr_t faddr_q, faddr_d;
    fetch_addr_t disc_addr_q, disc_addr_d;
    logic        discard_q, discard_d;

    // Handshakes: imem_req/imem_addr hold until imem_ack completes the single
    // outstanding read; the decoder takes an instruction on a cycle where
    // dec_valid && dec_ready, and dec_valid never waits on dec_ready.
    always_comb begin
        imem_req  = rst_n && (count < FULL_CNT);
        imem_addr = discard_q ? disc_addr_q : faddr_q;
        dec_valid = (count != '0) && !discard_q;
        ack_ok    = imem_req && imem_ack;
        push      = ack_ok && !discard_q && !flush;
        xfer      = dec_valid && dec_ready && !flush;
        pop       = xfer && (!thumb || pc_q[1]);
        code      = fifo_rdata;
        pc        = pc_q;
        addr1     = pc_q[1];
    end

    fetch_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (imem_rdata),
        .rdata (fifo_rdata),
        .count (count)
    );

    // A redirect with a read still in flight keeps presenting the old address
    // until that read acks, then the dropped word clears discard.
    always_comb begin
        pc_d        = pc_q;
        faddr_d     = faddr_q;
        discard_d   = discard_q;
        disc_addr_d = disc_addr_q;
        if (flush) begin
            pc_d      = align_pc(flush_addr, thumb);
            faddr_d   = word_align(flush_addr);
            discard_d = imem_req && !imem_ack;
            if (imem_req && !imem_ack && !discard_q) begin
                disc_addr_d = faddr_q;
            end
        end else begin
            if (xfer) begin
                pc_d = pc_q + (thumb ? STEP_THUMB : STEP_ARM);
            end
            if (push) begin
                faddr_d = faddr_q + STEP_ARM;
            end
            if (ack_ok && discard_q) begin
                discard_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            faddr_q     <= word_align(RESET_VECTOR);
            disc_addr_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            faddr_q     <= faddr_d;
            disc_addr_q <= disc_addr_d;
            discard_q   <= discard_d;
        end
    end

endmodule
